prio_rr_arbiter: RTL and testbench

Four-requester arbiter that shares a single downstream resource (a priority-encoded select path or shared bus port) between requesters. It resolves requests by fixed priority or by round-robin, holds a registered one-hot grant until the owner releases or a hold timeout expires, and reports the winner as an index. The block sits between the requester set and the shared resource and drives the resource's select input.

---
 rtl/prio_rr_arbiter_if.sv | 21 ++
 rtl/prio_rr_arbiter.sv | 104 ++++++++++
 tb/tb_prio_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_rr_arbiter_if.sv
// Request/grant bundle between a set of four requesters and the arbiter.
// The master side drives requests and release; the slave side is the arbiter.
interface prio_rr_arbiter_if;
  logic [3:0] req;
  logic       mode;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output req, mode, done,
    input  gnt, gnt_id, gnt_vld, timeout
  );

  modport slave (
    input  req, mode, done,
    output gnt, gnt_id, gnt_vld, timeout
  );
endinterface

// File: rtl/prio_rr_arbiter.sv
// Four-requester arbiter: fixed priority or round-robin selection, registered
// one-hot grant held until release, request drop or hold-limit expiry.
module prio_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  prio_rr_arbiter_if.slave  bus
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg;
  logic [3:0]    gnt_reg;
  logic [1:0]    gnt_id_reg;
  logic          gnt_vld_reg;
  logic [1:0]    last_id_reg;
  logic [CW-1:0] hold_cnt_reg;

  logic [1:0] fixed_win;
  logic [1:0] rr_win;
  logic [1:0] win_next;
  logic [1:0] rr_cand [4];
  logic [3:0] rr_hit;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  // Highest set index wins under fixed priority.
  always_comb begin
    fixed_win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) fixed_win = 2'(i);
    end
  end

  // Round-robin candidates in search order, starting just after the last owner.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rr
      assign rr_cand[gi] = last_id_reg + 2'(gi + 1);
      assign rr_hit[gi]  = bus.req[rr_cand[gi]];
    end
  endgenerate

  always_comb begin
    rr_win = rr_cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (rr_hit[k]) rr_win = rr_cand[k];
    end
  end

  assign win_next    = bus.mode ? rr_win : fixed_win;
  assign owner_req   = bus.req[gnt_id_reg];
  assign at_limit    = (hold_cnt_reg == HOLD_LAST);
  assign release_now = bus.done | ~owner_req | at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= 4'b0000;
      gnt_id_reg   <= 2'd0;
      gnt_vld_reg  <= 1'b0;
      last_id_reg  <= 2'd3;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg    <= GRANT;
            gnt_reg      <= 4'b0001 << win_next;
            gnt_id_reg   <= win_next;
            gnt_vld_reg  <= 1'b1;
            last_id_reg  <= win_next;
            hold_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_reg    <= IDLE;
            gnt_reg      <= 4'b0000;
            gnt_id_reg   <= 2'd0;
            gnt_vld_reg  <= 1'b0;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.gnt_vld = gnt_vld_reg;
  // The pulse is qualified by this cycle's release inputs so it flags only a
  // release caused by the hold limit alone, in the final grant cycle.
  assign bus.timeout = (state_reg == GRANT) & at_limit & ~bus.done & owner_req;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter: one task per scenario, inline checks of
// the packed output vector {gnt, gnt_vld, gnt_id, timeout} against hand values.
module tb_prio_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_rr_arbiter_if bus16 ();
  prio_rr_arbiter_if bus4 ();

  prio_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  prio_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  function automatic logic [7:0] outs16();
    return {bus16.gnt, bus16.gnt_vld, bus16.gnt_id, bus16.timeout};
  endfunction

  function automatic logic [7:0] outs4();
    return {bus4.gnt, bus4.gnt_vld, bus4.gnt_id, bus4.timeout};
  endfunction

  function automatic logic [5:0] idle16();
    return {bus16.gnt, bus16.gnt_vld, bus16.timeout};
  endfunction

  function automatic logic [5:0] idle4();
    return {bus4.gnt, bus4.gnt_vld, bus4.timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b1;
    bus16.req = 4'b0000; bus16.mode = 1'b0; bus16.done = 1'b0;
    bus4.req  = 4'b0000; bus4.mode  = 1'b0; bus4.done  = 1'b0;
    step(); step();
    checks++;
    if (outs16() !== 8'h00) begin
      errors++; $display("FAIL reset_values: got %b expected %b", outs16(), 8'h00);
    end
    checks++;
    if (outs4() !== 8'h00) begin
      errors++; $display("FAIL reset_values_hold4: got %b expected %b", outs4(), 8'h00);
    end
    rst = 1'b0;
    bus16.req = 4'b1111;
    step();
    exp = {4'b1000, 1'b1, 2'd3, 1'b0};
    checks++;
    if (outs16() !== exp) begin
      errors++; $display("FAIL reset_pre_grant: got %b expected %b", outs16(), exp);
    end
    rst = 1'b1;
    step();
    checks++;
    if (outs16() !== 8'h00) begin
      errors++; $display("FAIL reset_mid_grant: got %b expected %b", outs16(), 8'h00);
    end
    rst = 1'b0;
    bus16.mode = 1'b1;
    step();
    exp = {4'b0001, 1'b1, 2'd0, 1'b0};
    checks++;
    if (outs16() !== exp) begin
      errors++; $display("FAIL reset_first_rr_grant: got %b expected %b", outs16(), exp);
    end
    $display("reset: first round-robin grant gnt=%b", bus16.gnt);
    bus16.req = 4'b0000;
    step();
    checks++;
    if (idle16() !== 6'b0) begin
      errors++; $display("FAIL reset_release: got %b expected %b", idle16(), 6'b0);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] pats [3] = '{4'b0110, 4'b0011, 4'b1001};
    logic [1:0] ids  [3] = '{2'd2, 2'd1, 2'd3};
    logic [3:0] ohs  [3] = '{4'b0100, 4'b0010, 4'b1000};
    logic [7:0] exp;
    bus16.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus16.req  = pats[i];
      bus16.done = 1'b0;
      step();
      exp = {ohs[i], 1'b1, ids[i], 1'b0};
      checks++;
      if (outs16() !== exp) begin
        errors++; $display("FAIL fixed_grant_%0d: got %b expected %b", i, outs16(), exp);
      end
      $display("fixed: req=%b gnt_id=%0d", pats[i], bus16.gnt_id);
      bus16.done = 1'b1;
      step();
      checks++;
      if (idle16() !== 6'b0) begin
        errors++; $display("FAIL fixed_gap_%0d: got %b expected %b", i, idle16(), 6'b0);
      end
    end
    bus16.done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp;
    bus16.mode = 1'b1;
    bus16.req  = 4'b1111;
    bus16.done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {4'b0001 << seq[i], 1'b1, seq[i], 1'b0};
      checks++;
      if (outs16() !== exp) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, outs16(), exp);
      end
      $display("round-robin: gnt_id=%0d", bus16.gnt_id);
      bus16.done = 1'b1;
      step();
      bus16.done = 1'b0;
      checks++;
      if (idle16() !== 6'b0) begin
        errors++; $display("FAIL rr_gap_%0d: got %b expected %b", i, idle16(), 6'b0);
      end
    end
    bus16.req = 4'b0000;
    step();
  endtask

  task automatic test_request_drop();
    logic [7:0] exp;
    bus16.mode = 1'b0;
    bus16.req  = 4'b0100;
    exp = {4'b0100, 1'b1, 2'd2, 1'b0};
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (outs16() !== exp) begin
        errors++; $display("FAIL drop_hold_%0d: got %b expected %b", c, outs16(), exp);
      end
    end
    bus16.req = 4'b0000;
    #1;
    checks++;
    if (bus16.timeout !== 1'b0) begin
      errors++; $display("FAIL drop_timeout: got %b expected %b", bus16.timeout, 1'b0);
    end
    step();
    checks++;
    if (idle16() !== 6'b0) begin
      errors++; $display("FAIL drop_release: got %b expected %b", idle16(), 6'b0);
    end
    $display("request drop: gnt=%b timeout=%b", bus16.gnt, bus16.timeout);
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    bus4.mode = 1'b1;
    bus4.req  = 4'b1010;
    bus4.done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      exp = {4'b0010, 1'b1, 2'd1, (c == 3) ? 1'b1 : 1'b0};
      checks++;
      if (outs4() !== exp) begin
        errors++; $display("FAIL timeout_hold_%0d: got %b expected %b", c, outs4(), exp);
      end
    end
    $display("timeout: requester 1 force-released, timeout=%b", bus4.timeout);
    step();
    checks++;
    if (idle4() !== 6'b0) begin
      errors++; $display("FAIL timeout_gap: got %b expected %b", idle4(), 6'b0);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 3) begin
        bus4.done = 1'b1;
        #1;
      end
      exp = {4'b1000, 1'b1, 2'd3, 1'b0};
      checks++;
      if (outs4() !== exp) begin
        errors++; $display("FAIL timeout_done_hold_%0d: got %b expected %b", c, outs4(), exp);
      end
    end
    $display("timeout: requester 3 released by done, timeout=%b", bus4.timeout);
    step();
    bus4.done = 1'b0;
    checks++;
    if (idle4() !== 6'b0) begin
      errors++; $display("FAIL timeout_done_gap: got %b expected %b", idle4(), 6'b0);
    end
    step();
    exp = {4'b0010, 1'b1, 2'd1, 1'b0};
    checks++;
    if (outs4() !== exp) begin
      errors++; $display("FAIL timeout_rr_next: got %b expected %b", outs4(), exp);
    end
    bus4.req = 4'b0000;
    step();
  endtask

  task automatic test_no_preemption();
    logic [7:0] exp;
    bus16.mode = 1'b0;
    bus16.done = 1'b0;
    bus16.req  = 4'b0001;
    step();
    bus16.req = 4'b1001;
    exp = {4'b0001, 1'b1, 2'd0, 1'b0};
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (outs16() !== exp) begin
        errors++; $display("FAIL preempt_hold_%0d: got %b expected %b", c, outs16(), exp);
      end
      step();
    end
    bus16.done = 1'b1;
    step();
    bus16.done = 1'b0;
    checks++;
    if (idle16() !== 6'b0) begin
      errors++; $display("FAIL preempt_release: got %b expected %b", idle16(), 6'b0);
    end
    step();
    exp = {4'b1000, 1'b1, 2'd3, 1'b0};
    checks++;
    if (outs16() !== exp) begin
      errors++; $display("FAIL preempt_next: got %b expected %b", outs16(), exp);
    end
    $display("no preemption: next owner gnt_id=%0d", bus16.gnt_id);
    bus16.req = 4'b0000;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_request_drop();
    test_timeout();
    test_no_preemption();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
